// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: FSM states, coin codes
// and the credit unit.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam int UNIT = 5;

    // Credit value of a coin code; invalid and empty codes are worth nothing.
    function automatic int unsigned coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  coin_units = 5;
            COIN_10: coin_units = 10;
            default: coin_units = 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Dispense acknowledge watchdog: armed by start, stopped by ack, and flags
// expired during the TIMEOUT-th cycle after start without an ack.
module vend_ack_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          run;
    logic [TW-1:0] cnt;

    // expired stays combinational so the FSM can leave DISPENSE on the same edge.
    assign expired = run && (cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            if (ack || expired) begin
                run <= 1'b0;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: accumulates coins, runs the dispense handshake with a
// timeout, and (with CHANGE_EN defined) pays out leftover credit in 5-unit pulses.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE       = 15,
    parameter int MAX_CREDIT  = 30,
    parameter int ACK_TIMEOUT = 8,
    parameter int CW          = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic          sel,
    input  logic          cancel,
    input  logic          disp_ack,
    output logic          disp_req,
    output logic          chg_pulse,
    output logic          coin_rej,
    output logic [CW-1:0] credit,
    output logic          busy,
    output logic          disp_err
);
`ifdef CHANGE_EN
    localparam state_t LEFTOVER = CHANGE;
`else
    localparam state_t LEFTOVER = CREDIT;
`endif

    state_t        state, state_n;
    logic [CW-1:0] credit_n, coin_val;
    logic [CW:0]   sum;
    logic          disp_req_n, coin_rej_n, disp_err_n, busy_n;
    logic          coin_fits, sel_ok, expired;

    assign coin_val  = CW'(coin_units(coin));
    assign sum       = {1'b0, credit} + {1'b0, coin_val};
    assign coin_fits = ((coin == COIN_5) || (coin == COIN_10)) && (sum <= (CW+1)'(MAX_CREDIT));
    // sel is judged on the pre-coin credit, so a same-cycle coin cannot enable it.
    assign sel_ok    = (state == CREDIT) && sel && (credit >= CW'(PRICE));

    vend_ack_timer #(.TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (sel_ok),
        .ack     (disp_ack),
        .expired (expired)
    );

`ifdef CHANGE_EN
    logic chg_pulse_n;
`else
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    always_comb begin
        state_n    = state;
        credit_n   = credit;
        disp_req_n = 1'b0;
        disp_err_n = 1'b0;
`ifdef CHANGE_EN
        chg_pulse_n = 1'b0;
`endif
        coin_rej_n = (coin != COIN_NONE) &&
                     !(((state == IDLE) || (state == CREDIT)) && coin_fits);
        case (state)
            IDLE, CREDIT: begin
                if (coin_fits) credit_n = sum[CW-1:0];
                if (sel_ok) begin
                    state_n    = DISPENSE;
                    disp_req_n = 1'b1;
                end
`ifdef CHANGE_EN
                else if ((state == CREDIT) && cancel) state_n = CHANGE;
`endif
                else state_n = (credit_n != '0) ? CREDIT : IDLE;
            end
            DISPENSE: begin
                if (disp_ack) begin
                    credit_n = credit - CW'(PRICE);
                    state_n  = (credit_n != '0) ? LEFTOVER : IDLE;
                end else if (expired) begin
                    disp_err_n = 1'b1;
                    state_n    = LEFTOVER;
                end else begin
                    disp_req_n = 1'b1;
                end
            end
`ifdef CHANGE_EN
            CHANGE: begin
                if (credit != '0) begin
                    credit_n    = credit - CW'(UNIT);
                    chg_pulse_n = 1'b1;
                end
                if (credit_n == '0) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == DISPENSE) || (state_n == CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            credit   <= '0;
            disp_req <= 1'b0;
            coin_rej <= 1'b0;
            busy     <= 1'b0;
            disp_err <= 1'b0;
        end else begin
            state    <= state_n;
            credit   <= credit_n;
            disp_req <= disp_req_n;
            coin_rej <= coin_rej_n;
            busy     <= busy_n;
            disp_err <= disp_err_n;
        end
    end

`ifdef CHANGE_EN
    always_ff @(posedge clk) begin
        if (rst) chg_pulse <= 1'b0;
        else     chg_pulse <= chg_pulse_n;
    end
`else
    assign chg_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios plus random traffic,
// every cycle compared against a purchase-level reference model.
module tb_vend_sequencer;
    localparam int PRICE = 15, MAX_CREDIT = 30, ACK_TIMEOUT = 8, CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    coin = 2'b00;
    logic          sel = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
    logic          disp_req, chg_pulse, coin_rej, busy, disp_err;
    logic [CW-1:0] credit;

    int total = 0, bad = 0;

    vend_sequencer #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .ACK_TIMEOUT(ACK_TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel), .disp_ack(disp_ack),
        .disp_req(disp_req), .chg_pulse(chg_pulse), .coin_rej(coin_rej),
        .credit(credit), .busy(busy), .disp_err(disp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 = taking coins, 1 = waiting for the dispenser,
    // 2 = paying out change; waited counts dispenser cycles without an ack.
    int m_credit = 0, m_phase = 0, m_waited = 0;
    bit e_req, e_chg, e_rej, e_busy, e_err;
`ifdef CHANGE_EN
    localparam bit HAS_CHANGE = 1'b1;
`else
    localparam bit HAS_CHANGE = 1'b0;
`endif

    task automatic model(input logic [1:0] c, input logic s, input logic cn, input logic a, input logic r);
        int val;
        e_rej = 0; e_err = 0; e_chg = 0;
        val = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
        if (r) begin
            m_credit = 0; m_phase = 0; m_waited = 0;
        end else if (m_phase == 0) begin
            if (c == 2'b11 || (val > 0 && m_credit + val > MAX_CREDIT)) begin
                e_rej = 1; val = 0;
            end
            if (s && m_credit >= PRICE) begin
                m_phase = 1; m_waited = 0;
            end else if (HAS_CHANGE && cn && m_credit > 0) begin
                m_phase = 2;
            end
            m_credit += val;
        end else if (m_phase == 1) begin
            e_rej = (c != 2'b00);
            if (a) begin
                m_credit -= PRICE;
                m_phase = (m_credit > 0 && HAS_CHANGE) ? 2 : 0;
            end else begin
                m_waited++;
                if (m_waited == ACK_TIMEOUT) begin
                    e_err = 1;
                    m_phase = HAS_CHANGE ? 2 : 0;
                end
            end
        end else begin
            e_rej = (c != 2'b00);
            m_credit -= 5; e_chg = 1;
            if (m_credit == 0) m_phase = 0;
        end
        e_req  = (m_phase == 1);
        e_busy = (m_phase != 0);
    endtask

    task automatic tick(input logic [1:0] c, input logic s, input logic cn, input logic a, input logic r);
        coin = c; sel = s; cancel = cn; disp_ack = a; rst = r;
        model(c, s, cn, a, r);
        @(posedge clk); #1;
        chk("credit", int'(credit), m_credit);
        chk("disp_req", int'(disp_req), int'(e_req));
        chk("chg_pulse", int'(chg_pulse), int'(e_chg));
        chk("coin_rej", int'(coin_rej), int'(e_rej));
        chk("busy", int'(busy), int'(e_busy));
        chk("disp_err", int'(disp_err), int'(e_err));
        coin = 2'b00; sel = 0; cancel = 0; disp_ack = 0; rst = 0;
    endtask

    task automatic nop(); tick(2'b00, 0, 0, 0, 0); endtask
    task automatic put(input logic [1:0] c); tick(c, 0, 0, 0, 0); endtask
    task automatic do_reset(); tick(2'b00, 0, 0, 0, 1); endtask

    initial begin
        int n_req, n_err, n_chg;

        // Reset state
        do_reset();
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);

        // Purchase: 10 + 5, sel, ack three cycles after disp_req
        put(2'b10); put(2'b01);
        chk("buy_credit15", int'(credit), 15);
        tick(2'b00, 1, 0, 0, 0);
        chk("buy_req_up", int'(disp_req), 1);
        nop(); nop();
        tick(2'b00, 0, 0, 1, 0);
        chk("buy_req_down", int'(disp_req), 0);
        chk("buy_credit0", int'(credit), 0);
        n_chg = 0;
        for (int i = 0; i < 4; i++) begin nop(); n_chg += int'(chg_pulse); end
        chk("buy_no_change", n_chg, 0);

        // Change: 10 + 10, buy, 5 units left over
        do_reset();
        put(2'b10); put(2'b10);
        chk("chg_credit20", int'(credit), 20);
        tick(2'b00, 1, 0, 0, 0);
        tick(2'b00, 0, 0, 1, 0);
        chk("chg_credit5", int'(credit), 5);
        n_chg = 0;
        for (int i = 0; i < 4; i++) begin nop(); n_chg += int'(chg_pulse); end
        chk("chg_pulses", n_chg, HAS_CHANGE ? 1 : 0);
        chk("chg_end_credit", int'(credit), HAS_CHANGE ? 0 : 5);

        // Overflow and invalid code
        do_reset();
        put(2'b10); put(2'b10); put(2'b01);
        put(2'b10);
        chk("ovf_rej", int'(coin_rej), 1);
        chk("ovf_credit25", int'(credit), 25);
        do_reset();
        put(2'b11);
        chk("bad_rej", int'(coin_rej), 1);
        chk("bad_credit0", int'(credit), 0);

        // Timeout: credit 15, sel, no ack
        do_reset();
        put(2'b10); put(2'b01);
        tick(2'b00, 1, 0, 0, 0);
        n_req = int'(disp_req); n_err = 0; n_chg = 0;
        for (int i = 0; i < 16; i++) begin
            nop();
            n_req += int'(disp_req); n_err += int'(disp_err); n_chg += int'(chg_pulse);
        end
        chk("to_req_cycles", n_req, ACK_TIMEOUT);
        chk("to_err_pulse", n_err, 1);
        chk("to_chg_pulses", n_chg, HAS_CHANGE ? 3 : 0);

        // Collisions: coin with sel below price, then sel with cancel
        do_reset();
        put(2'b10);
        tick(2'b01, 1, 0, 0, 0);
        chk("col_sel_ignored", int'(disp_req), 0);
        chk("col_credit15", int'(credit), 15);
        tick(2'b00, 1, 1, 0, 0);
        chk("col_sel_wins", int'(disp_req), 1);
        tick(2'b00, 0, 0, 1, 0);
        chk("col_done_credit", int'(credit), 0);

        // Reset in the middle of change payout
        do_reset();
        put(2'b10); put(2'b10); put(2'b01);
        tick(2'b00, 1, 0, 0, 0);
        tick(2'b00, 0, 0, 1, 0);
        chk("rc_credit10", int'(credit), 10);
        do_reset();
        chk("rc_credit0", int'(credit), 0);
        chk("rc_chg0", int'(chg_pulse), 0);
        chk("rc_busy0", int'(busy), 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [1:0] c;
            c = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            tick(c, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
